rv64_exec_alu: RTL and testbench
================================

Name: rv64_exec_alu

Overview:
- RV64I integer ALU for the execute stage of the multi-cycle core.
- Decoder supplies a one-hot op, an instruction type, an immediate and a shift amount; reg-file supplies two operands.
- Computes one 64-bit result per accepted request; result is registered toward writeback.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- OP_W, 11, one-hot opcode width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  request strobe; operands sampled when high
- opcode  in  11  one-hot op, see Behaviour
- instr_type  in  4  operand/width class
- value1  in  64  rs1 value
- value2  in  64  rs2 value
- immediate  in  32  decoder immediate, signed
- shamt  in  6  immediate shift amount
- result  out  64  registered result
- result_valid  out  1  high one cycle after an accepted in_valid
- illegal  out  1  registered; op/type combination unsupported

Behaviour:
- Reset (reset=0, async): result=0, result_valid=0, illegal=0.
  - Deassertion takes effect at the next clk edge.
  - Reset mid-operation discards the pending result.
- Latency: 1 cycle. in_valid at edge N gives result/result_valid/illegal at edge N+1.
  - Back-to-back requests every cycle are supported.
  - in_valid=0: result and illegal hold, result_valid=0.
- opcode one-hot bits:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS.
- instr_type encoding:
  - 0 R: B = value2.
  - 1 I: B = sext64(immediate).
  - 2 RW: 32-bit op, B = value2.
  - 3 IW: 32-bit op, B = sext64(immediate).
  - 4 U: result = sext64(immediate); the immediate is already shifted by 12; opcode must be PASS.
  - 5-15: illegal.
- Shift amount:
  - Types R, RW: value2[5:0] for R, value2[4:0] for RW.
  - Types I, IW: shamt[5:0] for I, shamt[4:0] for IW.
- W types:
  - Operate on the low 32 bits; result = sext64(32-bit result).
  - Only ADD, SUB, SLL, SRL, SRA are legal; SUB is illegal for IW.
  - SRAW uses value1[31] as the fill bit.
- Comparisons:
  - SLT is signed, SLTU is unsigned.
  - Both return 64'd0 or 64'd1.
  - SLTU with B = sext(imm) compares as unsigned 64-bit.
- Arithmetic wraps modulo 2^64 (2^32 for W types); no overflow flag.
- SUB is legal only for types R and RW.
- PASS is legal only for type U.
- Illegal cases:
  - opcode zero or multi-hot, or any illegal op/type pair.
  - Response: result=0, illegal=1, result_valid still asserted.

Optional Feature:
- Macro ALU_COMB_OUT_EN.
- Defined:
  - result and illegal are combinational from the inputs (0 latency); result_valid = in_valid.
  - reset has no effect on the outputs.
- Undefined: registered 1-cycle behaviour as above.

Decomposition:
- Package alu_pkg:
  - OP_ADD..OP_PASS bit-index localparams.
  - instr_type enum (IT_R, IT_I, IT_RW, IT_IW, IT_U).
  - XLEN constant.
- Sub-module alu_shifter: 64/32-bit SLL/SRL/SRA.
  - Inputs: data, amount[5:0], word, op.
  - Output: sign-extended result.

Test Plan:
- Reset low during activity -> result=0, result_valid=0, illegal=0 immediately. Release, then ADD R value1=5, value2=7 -> result=12 next cycle.
- SUB R value1=0, value2=1 -> 0xFFFF_FFFF_FFFF_FFFF. ADD IW value1=0x7FFF_FFFF, imm=1 -> 0xFFFF_FFFF_8000_0000.
- SRA I value1=0x8000_0000_0000_0000, shamt=63 -> all ones. SRL RW value1=0x8000_0000, value2=0x21 (shift 1) -> 0x4000_0000.
- SLT R value1=-1, value2=1 -> 1. SLTU R on the same operands -> 0. SLTU I value1=5, imm=-1 -> 1.
- PASS U imm=0x12345000 -> 0x0000_0000_1234_5000. PASS U imm=0x80000000 -> 0xFFFF_FFFF_8000_0000.
- opcode=0, then opcode=11'b11, then SUB with type IW -> each gives illegal=1, result=0, result_valid=1. Back-to-back valid ADDs give results on consecutive cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the RV64I execute-stage ALU.
//   - XLEN / OP_W      : datapath and one-hot opcode widths
//   - OP_* indices     : bit positions inside the one-hot opcode
//   - instr_type_e     : operand/width class supplied by the decoder
//   - shift_op_e       : operation select for alu_shifter
//   - LEGAL_*          : per-type masks of the opcodes that type accepts
//   - sext32()         : sign-extend a 32-bit value to XLEN
package alu_pkg;

    localparam int XLEN = 64;
    localparam int OP_W = 11;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLL  = 2;
    localparam int OP_SLT  = 3;
    localparam int OP_SLTU = 4;
    localparam int OP_XOR  = 5;
    localparam int OP_SRL  = 6;
    localparam int OP_SRA  = 7;
    localparam int OP_OR   = 8;
    localparam int OP_AND  = 9;
    localparam int OP_PASS = 10;

    typedef enum logic [3:0] {
        IT_R  = 4'd0,
        IT_I  = 4'd1,
        IT_RW = 4'd2,
        IT_IW = 4'd3,
        IT_U  = 4'd4
    } instr_type_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_op_e;

    // Register forms accept everything except PASS; immediate forms also
    // drop SUB. Word forms keep only add/sub and the three shifts.
    localparam logic [OP_W-1:0] LEGAL_R  = 11'b011_1111_1111;
    localparam logic [OP_W-1:0] LEGAL_I  = 11'b011_1111_1101;
    localparam logic [OP_W-1:0] LEGAL_RW = 11'b000_1100_0111;
    localparam logic [OP_W-1:0] LEGAL_IW = 11'b000_1100_0101;
    localparam logic [OP_W-1:0] LEGAL_U  = 11'b100_0000_0000;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return {{(XLEN-32){x[31]}}, x};
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational 64/32-bit shifter.
//   data   : value to shift
//   amount : shift distance; only [4:0] is used when word=1
//   word   : 1 = operate on data[31:0] and sign-extend the 32-bit result
//   op     : SH_SLL / SH_SRL / SH_SRA
//   result : shifted value (sign-extended from bit 31 in word mode)
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [5:0]      amount,
    input  logic            word,
    input  shift_op_e       op,
    output logic [XLEN-1:0] result
);

    logic [31:0] word_res;
    logic [XLEN-1:0] dword_res;

    always_comb begin
        word_res  = '0;
        dword_res = '0;
        case (op)
            SH_SLL: begin
                word_res  = data[31:0] << amount[4:0];
                dword_res = data << amount;
            end
            SH_SRL: begin
                word_res  = data[31:0] >> amount[4:0];
                dword_res = data >> amount;
            end
            SH_SRA: begin
                // Word arithmetic shift fills from bit 31, not bit 63.
                word_res  = 32'($signed(data[31:0]) >>> amount[4:0]);
                dword_res = XLEN'($signed(data) >>> amount);
            end
            default: begin
                word_res  = '0;
                dword_res = '0;
            end
        endcase
    end

    assign result = word ? sext32(word_res) : dword_res;

endmodule

// File: rtl/rv64_exec_alu.sv
// RV64I integer ALU for the execute stage.
//   clk, reset      : rising-edge clock, asynchronous active-low reset
//   in_valid        : request strobe
//   opcode          : one-hot operation (alu_pkg OP_* bit indices)
//   instr_type      : R / I / RW / IW / U operand class, 5..15 illegal
//   value1, value2  : rs1 / rs2 operands
//   immediate       : signed decoder immediate (U type pre-shifted by 12)
//   shamt           : immediate shift amount
//   result          : 64-bit result (0 when illegal)
//   result_valid    : one cycle after an accepted request
//   illegal         : unsupported opcode / type combination
// Build option: define ALU_COMB_OUT_EN to make result/illegal combinational
// from the inputs with result_valid = in_valid and reset not affecting the
// outputs. Default: outputs registered with one cycle of latency.
module rv64_exec_alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [OP_W-1:0] opcode,
    input  logic [3:0]      instr_type,
    input  logic [XLEN-1:0] value1,
    input  logic [XLEN-1:0] value2,
    input  logic [31:0]     immediate,
    input  logic [5:0]      shamt,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            illegal
);

    logic [XLEN-1:0] imm_sext;
    logic            is_imm;
    logic            is_word;
    logic [XLEN-1:0] op_b;
    logic [5:0]      sh_amt;
    logic [XLEN-1:0] add_sum;
    logic [XLEN-1:0] sub_diff;
    logic [XLEN-1:0] sh_res [3];
    logic [XLEN-1:0] op_res [OP_W];
    logic [XLEN-1:0] op_masked [OP_W];
    logic [XLEN-1:0] op_sel;
    logic [OP_W-1:0] legal_mask;
    logic            opcode_onehot;
    logic            is_illegal;
    logic [XLEN-1:0] alu_result;

    assign imm_sext = sext32(immediate);
    assign is_imm   = (instr_type == IT_I)  || (instr_type == IT_IW);
    assign is_word  = (instr_type == IT_RW) || (instr_type == IT_IW);
    assign op_b     = is_imm ? imm_sext : value2;
    // Bit 5 of the amount is ignored by the shifter in word mode, so the
    // 6-bit source can be passed straight through for every type.
    assign sh_amt   = is_imm ? shamt : value2[5:0];
    assign add_sum  = value1 + op_b;
    assign sub_diff = value1 - op_b;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_shift
            alu_shifter u_shifter (
                .data   (value1),
                .amount (sh_amt),
                .word   (is_word),
                .op     (shift_op_e'(2'(gi))),
                .result (sh_res[gi])
            );
        end
    endgenerate

    always_comb begin
        op_res[OP_ADD]  = is_word ? sext32(add_sum[31:0])  : add_sum;
        op_res[OP_SUB]  = is_word ? sext32(sub_diff[31:0]) : sub_diff;
        op_res[OP_SLL]  = sh_res[0];
        op_res[OP_SLT]  = {{(XLEN-1){1'b0}}, ($signed(value1) < $signed(op_b))};
        op_res[OP_SLTU] = {{(XLEN-1){1'b0}}, (value1 < op_b)};
        op_res[OP_XOR]  = value1 ^ op_b;
        op_res[OP_SRL]  = sh_res[1];
        op_res[OP_SRA]  = sh_res[2];
        op_res[OP_OR]   = value1 | op_b;
        op_res[OP_AND]  = value1 & op_b;
        op_res[OP_PASS] = imm_sext;
    end

    // AND-OR result select keyed directly by the one-hot opcode.
    generate
        for (gi = 0; gi < OP_W; gi++) begin : g_sel
            assign op_masked[gi] = opcode[gi] ? op_res[gi] : '0;
        end
    endgenerate

    always_comb begin
        op_sel = '0;
        for (int i = 0; i < OP_W; i++) begin
            op_sel = op_sel | op_masked[i];
        end
    end

    always_comb begin
        legal_mask = '0;
        case (instr_type)
            IT_R:    legal_mask = LEGAL_R;
            IT_I:    legal_mask = LEGAL_I;
            IT_RW:   legal_mask = LEGAL_RW;
            IT_IW:   legal_mask = LEGAL_IW;
            IT_U:    legal_mask = LEGAL_U;
            default: legal_mask = '0;
        endcase
    end

    assign opcode_onehot = (opcode != '0) && ((opcode & (opcode - 1'b1)) == '0);
    assign is_illegal    = !(opcode_onehot && ((opcode & legal_mask) != '0));
    assign alu_result    = is_illegal ? '0 : op_sel;

`ifdef ALU_COMB_OUT_EN
    assign result       = alu_result;
    assign illegal      = is_illegal;
    assign result_valid = in_valid;
`else
    logic [XLEN-1:0] result_reg;
    logic            result_valid_reg;
    logic            illegal_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            illegal_reg      <= 1'b0;
        end else begin
            result_valid_reg <= in_valid;
            if (in_valid) begin
                result_reg  <= alu_result;
                illegal_reg <= is_illegal;
            end
        end
    end

    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign illegal      = illegal_reg;
`endif

endmodule

// File: tb/tb_rv64_exec_alu.sv
module tb_rv64_exec_alu;
    import alu_pkg::*;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic [OP_W-1:0] opcode;
    logic [3:0]      instr_type;
    logic [63:0]     value1;
    logic [63:0]     value2;
    logic [31:0]     immediate;
    logic [5:0]      shamt;
    logic [63:0]     result;
    logic            result_valid;
    logic            illegal;

    rv64_exec_alu dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .opcode       (opcode),
        .instr_type   (instr_type),
        .value1       (value1),
        .value2       (value2),
        .immediate    (immediate),
        .shamt        (shamt),
        .result       (result),
        .result_valid (result_valid),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OP_W-1:0] op;
        logic [3:0]      it;
        logic [63:0]     v1;
        logic [63:0]     v2;
        logic [31:0]     imm;
        logic [5:0]      sh;
        logic [63:0]     exp;
        logic            ill;
    } vec_t;

    typedef struct {
        logic [63:0] exp;
        logic        ill;
        int          idx;
    } sb_t;

    localparam int NV = 26;
    vec_t vecs [NV];
    sb_t  sb [$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [OP_W-1:0] oh(input int idx);
        logic [OP_W-1:0] one;
        one = 1;
        return one << idx;
    endfunction

    function automatic vec_t mk(input logic [OP_W-1:0] op, input logic [3:0] it,
                                input logic [63:0] v1, input logic [63:0] v2,
                                input logic [31:0] imm, input logic [5:0] sh,
                                input logic [63:0] exp, input logic ill);
        vec_t v;
        v.op = op; v.it = it; v.v1 = v1; v.v2 = v2;
        v.imm = imm; v.sh = sh; v.exp = exp; v.ill = ill;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input int idx);
        opcode     = v.op;
        instr_type = v.it;
        value1     = v.v1;
        value2     = v.v2;
        immediate  = v.imm;
        shamt      = v.sh;
        in_valid   = 1'b1;
        sb.push_back('{exp: v.exp, ill: v.ill, idx: idx});
        $display("drive vec%0d op=%b type=%0d v1=0x%016h v2=0x%016h imm=0x%08h shamt=%0d",
                 idx, v.op, v.it, v.v1, v.v2, v.imm, v.sh);
    endtask

    // Scoreboard consumer: every valid output must match the oldest request.
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got result_valid=1 expected no pending request");
            end else begin
                e = sb.pop_front();
                check($sformatf("vec%0d_result", e.idx), result, e.exp);
                check($sformatf("vec%0d_illegal", e.idx), {63'd0, illegal}, {63'd0, e.ill});
                $display("result vec%0d result=0x%016h illegal=%0b", e.idx, result, illegal);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t pre;
        int k;

        vecs[0]  = mk(oh(OP_ADD),  4'd0, 64'd5, 64'd7, 32'd0, 6'd0, 64'd12, 1'b0);
        vecs[1]  = mk(oh(OP_SUB),  4'd0, 64'd0, 64'd1, 32'd0, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        vecs[2]  = mk(oh(OP_ADD),  4'd3, 64'h7FFF_FFFF, 64'd0, 32'd1, 6'd0, 64'hFFFF_FFFF_8000_0000, 1'b0);
        vecs[3]  = mk(oh(OP_SRA),  4'd1, 64'h8000_0000_0000_0000, 64'd0, 32'd0, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        vecs[4]  = mk(oh(OP_SRL),  4'd2, 64'h8000_0000, 64'h21, 32'd0, 6'd0, 64'h4000_0000, 1'b0);
        vecs[5]  = mk(oh(OP_SLT),  4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'd0, 6'd0, 64'd1, 1'b0);
        vecs[6]  = mk(oh(OP_SLTU), 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'd0, 6'd0, 64'd0, 1'b0);
        vecs[7]  = mk(oh(OP_SLTU), 4'd1, 64'd5, 64'd0, 32'hFFFF_FFFF, 6'd0, 64'd1, 1'b0);
        vecs[8]  = mk(oh(OP_PASS), 4'd4, 64'd3, 64'd4, 32'h1234_5000, 6'd0, 64'h0000_0000_1234_5000, 1'b0);
        vecs[9]  = mk(oh(OP_PASS), 4'd4, 64'd0, 64'd0, 32'h8000_0000, 6'd0, 64'hFFFF_FFFF_8000_0000, 1'b0);
        vecs[10] = mk(11'd0,       4'd0, 64'd9, 64'd9, 32'd0, 6'd0, 64'd0, 1'b1);
        vecs[11] = mk(11'b11,      4'd0, 64'd9, 64'd9, 32'd0, 6'd0, 64'd0, 1'b1);
        vecs[12] = mk(oh(OP_SUB),  4'd3, 64'd9, 64'd0, 32'd1, 6'd0, 64'd0, 1'b1);
        vecs[13] = mk(oh(OP_XOR),  4'd1, 64'hF0F0, 64'd0, 32'hFFFF_FFFF, 6'd0, 64'hFFFF_FFFF_FFFF_0F0F, 1'b0);
        vecs[14] = mk(oh(OP_SLL),  4'd0, 64'd1, 64'h7F, 32'd0, 6'd0, 64'h8000_0000_0000_0000, 1'b0);
        vecs[15] = mk(oh(OP_SLL),  4'd3, 64'd1, 64'd0, 32'd0, 6'h3F, 64'hFFFF_FFFF_8000_0000, 1'b0);
        vecs[16] = mk(oh(OP_SRA),  4'd2, 64'h1234_5678_8000_0000, 64'd4, 32'd0, 6'd0, 64'hFFFF_FFFF_F800_0000, 1'b0);
        vecs[17] = mk(oh(OP_PASS), 4'd0, 64'd1, 64'd1, 32'h1000, 6'd0, 64'd0, 1'b1);
        vecs[18] = mk(oh(OP_ADD),  4'd5, 64'd1, 64'd1, 32'd0, 6'd0, 64'd0, 1'b1);
        vecs[19] = mk(oh(OP_OR),   4'd0, 64'h00FF, 64'hFF00, 32'd0, 6'd0, 64'hFFFF, 1'b0);
        vecs[20] = mk(oh(OP_AND),  4'd1, 64'h1234_5678_9ABC_DEF0, 64'd0, 32'h0FFF, 6'd0, 64'hEF0, 1'b0);
        vecs[21] = mk(oh(OP_SLT),  4'd1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 32'hFFFF_FFFD, 6'd0, 64'd1, 1'b0);
        vecs[22] = mk(oh(OP_SUB),  4'd2, 64'h0000_0001_0000_0005, 64'd3, 32'd0, 6'd0, 64'd2, 1'b0);
        vecs[23] = mk(oh(OP_XOR),  4'd3, 64'd1, 64'd0, 32'd1, 6'd0, 64'd0, 1'b1);
        vecs[24] = mk(oh(OP_ADD),  4'd4, 64'd1, 64'd0, 32'h1000, 6'd0, 64'd0, 1'b1);
        vecs[25] = mk(oh(OP_ADD),  4'd0, 64'h1234, 64'd1, 32'd0, 6'd0, 64'h1235, 1'b0);

        reset = 1'b0; in_valid = 1'b0; opcode = '0; instr_type = '0;
        value1 = '0; value2 = '0; immediate = '0; shamt = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_result", result, 64'd0);
        check("reset_valid", {63'd0, result_valid}, 64'd0);
        check("reset_illegal", {63'd0, illegal}, 64'd0);

        @(negedge clk);
        reset = 1'b1;

        // Reset asserted while a request is in flight.
        @(negedge clk);
        pre = mk(oh(OP_ADD), 4'd0, 64'd100, 64'd23, 32'd0, 6'd0, 64'd123, 1'b0);
        drive(pre, 99);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("midreset_result", result, 64'd0);
        check("midreset_valid", {63'd0, result_valid}, 64'd0);
        check("midreset_illegal", {63'd0, illegal}, 64'd0);
        @(posedge clk);
        #1;
        check("inreset_valid", {63'd0, result_valid}, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        sb.delete();

        // Back-to-back table: one request every cycle.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i], i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        value1 = 64'hDEAD;
        @(posedge clk);
        #2;
        check("idle_valid", {63'd0, result_valid}, 64'd0);
        check("idle_hold_result", result, 64'h1235);
        check("idle_hold_illegal", {63'd0, illegal}, 64'd0);

        // Illegal followed by idle: illegal flag holds too.
        @(negedge clk);
        drive(vecs[10], 10);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("idle_hold_illegal_set", {63'd0, illegal}, 64'd1);

        k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
